// File: rtl/mult32x32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult32x32_pkg
//  Description : Shared definitions for the fast 32x32 multiplier control
//                path: step-state encoding, sizing constants and the
//                partial-product shift helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult32x32_pkg;

    // Largest number of accumulate steps any operation can take.
    localparam int STEPS_MAX  = 8;
    // Bit distance between adjacent bytes of operand a.
    localparam int BYTE_SHIFT = 8;
    // Width of a counter that can hold 0..STEPS_MAX.
    localparam int CNT_W      = $clog2(STEPS_MAX + 1);

    // Encoding: bit3 = step state (busy), bit2 = b word, bits1:0 = a byte.
    // This lets the Moore outputs come straight off the state register.
    typedef enum logic [3:0] {
        IDLE = 4'b0000,
        A0B0 = 4'b1000,
        A1B0 = 4'b1001,
        A2B0 = 4'b1010,
        A3B0 = 4'b1011,
        A0B1 = 4'b1100,
        A1B1 = 4'b1101,
        A2B1 = 4'b1110,
        A3B1 = 4'b1111
    } state_t;

    // Left shift of the partial product a_byte[i] * b_word[j]:
    // 8 bits per a byte plus 16 bits per b word.
    function automatic logic [5:0] shift_amt(input logic [1:0] a_sel,
                                             input logic       b_sel);
        logic [5:0] sh;
        sh = 6'(a_sel) * 6'(BYTE_SHIFT);
        if (b_sel) begin
            sh = sh + 6'(2 * BYTE_SHIFT);
        end
        return sh;
    endfunction

endpackage : mult32x32_pkg
`default_nettype wire

// File: rtl/mult32x32_fast_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mult32x32_fast_fsm
//  Description : Control FSM for a byte-by-halfword 32x32 multiplier. Each
//                step state selects one byte of a and one 16-bit word of b
//                and tells the datapath to accumulate the shifted partial
//                product. Optional early termination when the top byte of a
//                and/or the upper word of b are zero.
//  Revision    : 1.0 - initial release
//
//  Configuration macro:
//    MULT32X32_FAST_SKIP_EN  defined   : zero-operand skipping enabled
//                            undefined : flags ignored, always 8 steps
//
//  Ports:
//    clk         in   clock, rising edge
//    reset       in   asynchronous active-high reset
//    start       in   begin a multiplication (sampled in IDLE only)
//    a_msb_is_0  in   a[31:24] == 0
//    b_msw_is_0  in   b[31:16] == 0
//    a_sel       out  [1:0] byte of a for this step
//    b_sel       out  word of b for this step
//    shift_sel   out  [5:0] partial-product left shift
//    upd_prod    out  product accumulate enable
//    clr_prod    out  product clear (start accepted in IDLE)
//    busy        out  high in every step state
//    done        out  one-cycle pulse, product valid
//    step_count  out  [3:0] steps used by the last completed operation
// ============================================================================
module mult32x32_fast_fsm
    import mult32x32_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       a_msb_is_0,
    input  logic       b_msw_is_0,
    output logic [1:0] a_sel,
    output logic       b_sel,
    output logic [5:0] shift_sel,
    output logic       upd_prod,
    output logic       clr_prod,
    output logic       busy,
    output logic       done,
    output logic [3:0] step_count
);

    state_t             state_q;
    state_t             state_d;
    logic               done_q;
    logic [CNT_W-1:0]   step_count_q;
    logic [CNT_W-1:0]   run_cnt_q;

    logic               w_busy;
    logic [1:0]         w_a_sel;
    logic               w_b_sel;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = A0B0;
            A0B0: state_d = A1B0;
            A1B0: state_d = A2B0;
`ifdef MULT32X32_FAST_SKIP_EN
            // b upper word zero: the B1 half contributes nothing, finish.
            // Otherwise a zero top byte lets us skip the A3 step.
            A2B0: begin
                if (b_msw_is_0)      state_d = IDLE;
                else if (a_msb_is_0) state_d = A0B1;
                else                 state_d = A3B0;
            end
            A3B0: state_d = b_msw_is_0 ? IDLE : A0B1;
`else
            A2B0: state_d = A3B0;
            A3B0: state_d = A0B1;
`endif
            A0B1: state_d = A1B1;
            A1B1: state_d = A2B1;
`ifdef MULT32X32_FAST_SKIP_EN
            A2B1: state_d = a_msb_is_0 ? IDLE : A3B1;
`else
            A2B1: state_d = A3B1;
`endif
            A3B1: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifndef MULT32X32_FAST_SKIP_EN
    // Flags are intentionally ignored when skipping is compiled out.
    logic w_unused_flags;
    assign w_unused_flags = a_msb_is_0 ^ b_msw_is_0;
`endif

    // ------------------------------------------------------------------
    // State, done pulse and step accounting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            step_count_q <= '0;
            run_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            // done lands in the first IDLE cycle after the last step.
            done_q  <= w_busy && (state_d == IDLE);
            if (w_busy) begin
                run_cnt_q <= run_cnt_q + CNT_W'(1);
                if (state_d == IDLE) begin
                    step_count_q <= run_cnt_q + CNT_W'(1);
                end
            end else begin
                run_cnt_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs decoded from the state encoding; gating with busy
    // keeps any illegal encoding from producing stray selects.
    // ------------------------------------------------------------------
    assign w_busy  = state_q[3];
    assign w_a_sel = w_busy ? state_q[1:0] : 2'b00;
    assign w_b_sel = w_busy & state_q[2];

    assign a_sel      = w_a_sel;
    assign b_sel      = w_b_sel;
    assign shift_sel  = shift_amt(w_a_sel, w_b_sel);
    assign upd_prod   = w_busy;
    assign busy       = w_busy;
    // Mealy: clear only when a start is actually accepted.
    assign clr_prod   = start && (state_q == IDLE);
    assign done       = done_q;
    assign step_count = step_count_q;

endmodule : mult32x32_fast_fsm
`default_nettype wire

// File: tb/tb_mult32x32_fast_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult32x32_fast_fsm
//  Description : Self-checking bench for mult32x32_fast_fsm. A small
//                datapath model accumulates partial products under control
//                of the FSM outputs; expected products and step counts are
//                queued when an operation is started and compared at done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult32x32_fast_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        a_msb_is_0;
    logic        b_msw_is_0;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [5:0]  shift_sel;
    logic        upd_prod;
    logic        clr_prod;
    logic        busy;
    logic        done;
    logic [3:0]  step_count;

    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [63:0] prod_m;

    typedef struct {
        logic [63:0] prod;
        int          steps;
    } exp_t;

    exp_t exp_q[$];
    int   obs_shift[$];
    int   obs_bsel[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_steps = 0;

    always #5 clk = ~clk;

    mult32x32_fast_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a_msb_is_0 (a_msb_is_0),
        .b_msw_is_0 (b_msw_is_0),
        .a_sel      (a_sel),
        .b_sel      (b_sel),
        .shift_sel  (shift_sel),
        .upd_prod   (upd_prod),
        .clr_prod   (clr_prod),
        .busy       (busy),
        .done       (done),
        .step_count (step_count)
    );

    assign a_msb_is_0 = (a_r[31:24] == 8'h00);
    assign b_msw_is_0 = (b_r[31:16] == 16'h0000);

    // Datapath model driven by the FSM controls.
    logic [7:0]  a_byte;
    logic [15:0] b_word;
    assign a_byte = a_r[8*a_sel +: 8];
    assign b_word = b_r[16*b_sel +: 16];

    always @(posedge clk or posedge reset) begin
        if (reset)         prod_m <= 64'd0;
        else if (clr_prod) prod_m <= 64'd0;
        else if (upd_prod) prod_m <= prod_m + ((64'(a_byte) * 64'(b_word)) << shift_sel);
    end

    function automatic int exp_steps(input logic [31:0] a_in, input logic [31:0] b_in);
`ifdef MULT32X32_FAST_SKIP_EN
        bit am;
        bit bm;
        am = (a_in[31:24] == 8'h00);
        bm = (b_in[31:16] == 16'h0000);
        if (bm) return am ? 3 : 4;
        return am ? 6 : 8;
`else
        return 8;
`endif
    endfunction

    // Starts one operation (optionally inside the current cycle, for
    // back-to-back issue from a done cycle) and checks it through done.
    task automatic do_op(input logic [31:0] a_in, input logic [31:0] b_in,
                         input bit sync, input bit hold);
        exp_t e;
        int   cyc;
        int   n;
        bit   seen;
        if (sync) @(negedge clk);
        a_r   = a_in;
        b_r   = b_in;
        start = 1'b1;
        n       = exp_steps(a_in, b_in);
        e.prod  = 64'(a_in) * 64'(b_in);
        e.steps = n;
        exp_q.push_back(e);
        obs_shift.delete();
        obs_bsel.delete();
        #1;
        n_tests++;
        if (clr_prod !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_accept: clr_prod=%b busy=%b, expected clr_prod=1 busy=0", clr_prod, busy);
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            start = hold && (cyc <= n);
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (upd_prod === 1'b1) begin
                    obs_shift.push_back(int'(shift_sel));
                    obs_bsel.push_back(int'(b_sel));
                end
                if (cyc == 1) begin
                    n_tests++;
                    if (step_count !== 4'(last_steps)) begin
                        n_fail++;
                        $display("FAIL step_count_hold: got %0d, expected %0d", step_count, last_steps);
                    end
                end
                if (cyc <= n) begin
                    n_tests++;
                    if (busy !== 1'b1 || upd_prod !== 1'b1 || clr_prod !== 1'b0) begin
                        n_fail++;
                        $display("FAIL step_outputs: cyc %0d busy=%b upd=%b clr=%b, expected 1 1 0",
                                 cyc, busy, upd_prod, clr_prod);
                    end
                end
            end
        end
        e = exp_q.pop_front();
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles, expected at cycle %0d", cyc, e.steps + 1);
        end else begin
            if (cyc != e.steps + 1) begin
                n_fail++;
                $display("FAIL latency: done at cycle %0d, expected %0d", cyc, e.steps + 1);
            end
            n_tests++;
            if (prod_m !== e.prod) begin
                n_fail++;
                $display("FAIL product: got %h, expected %h", prod_m, e.prod);
            end
            n_tests++;
            if (step_count !== 4'(e.steps)) begin
                n_fail++;
                $display("FAIL step_count: got %0d, expected %0d", step_count, e.steps);
            end
            n_tests++;
            if (obs_shift.size() != e.steps || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL upd_count: got %0d upd cycles busy=%b, expected %0d and busy=0",
                         obs_shift.size(), busy, e.steps);
            end
            last_steps = e.steps;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a_r   = 32'd0;
        b_r   = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({busy, done, step_count, upd_prod, clr_prod, a_sel, b_sel, shift_sel} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b sc=%0d upd=%b clr=%b a_sel=%0d b_sel=%b sh=%0d, expected all 0",
                     busy, done, step_count, upd_prod, clr_prod, a_sel, b_sel, shift_sel);
        end
        @(negedge clk);
        reset = 1'b0;
        last_steps = 0;
        // Idle with start low must stay idle.
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_full();
        int  exp_sh[8];
        int  exp_bs[8];
        bit  ok;
        exp_sh = '{0, 8, 16, 24, 16, 24, 32, 40};
        exp_bs = '{0, 0, 0, 0, 1, 1, 1, 1};
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        ok = (obs_shift.size() == 8);
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                if (obs_shift[i] != exp_sh[i] || obs_bsel[i] != exp_bs[i]) ok = 1'b0;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL shift_seq: got %p / b_sel %p, expected %p / %p", obs_shift, obs_bsel, exp_sh, exp_bs);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (done !== 1'b0 || step_count !== 4'd8) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b sc=%0d one cycle later, expected done=0 sc=8", done, step_count);
        end
    endtask

    task automatic test_skip();
        do_op(32'h00FF_FFFF, 32'h0000_FFFF, 1'b1, 1'b0);
        do_op(32'h1234_5678, 32'h0000_1000, 1'b1, 1'b0);
        do_op(32'h0012_3456, 32'h89AB_CDEF, 1'b1, 1'b0);
        do_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    endtask

    task automatic test_hold_start();
        do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_no_restart: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        do_op(32'hCAFE_F00D, 32'h1234_0000, 1'b1, 1'b0);
        do_op(32'h00AB_CDEF, 32'h0000_7777, 1'b0, 1'b0);
        do_op(32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit bad;
        @(negedge clk);
        a_r   = 32'hFFFF_FFFF;
        b_r   = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (a_sel !== 2'd2 || b_sel !== 1'b0 || shift_sel !== 6'd16) begin
            n_fail++;
            $display("FAIL in_a2b0: a_sel=%0d b_sel=%b sh=%0d, expected 2 0 16", a_sel, b_sel, shift_sel);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || upd_prod !== 1'b0 || done !== 1'b0 || step_count !== 4'd0 || prod_m !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%b upd=%b done=%b sc=%0d prod=%h, expected 0 0 0 0 0",
                     busy, upd_prod, done, step_count, prod_m);
        end
        @(negedge clk);
        reset = 1'b0;
        last_steps = 0;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL abort_no_done: activity seen after reset, expected idle");
        end
    endtask

    task automatic test_random();
        logic [31:0] a_v;
        logic [31:0] b_v;
        for (int i = 0; i < 8; i++) begin
            a_v = $urandom;
            b_v = $urandom;
            if (i % 2 == 1) a_v[31:24] = 8'h00;
            if ((i / 2) % 2 == 1) b_v[31:16] = 16'h0000;
            do_op(a_v, b_v, (i % 3) != 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_skip();
        test_hold_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mult32x32_fast_fsm
`default_nettype wire

// File: doc/mult32x32_fast_fsm.md
MULT32X32_FAST_FSM -- requirements
Module: mult32x32_fast_fsm

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 a_msb_is_0  input  1  from datapath; a[31:24]==0.
REQ-006 b_msw_is_0  input  1  from datapath; b[31:16]==0.
REQ-007 a_sel  output  2  byte of a selected for the current step.
REQ-008 b_sel  output  1  16-bit word of b selected for the current step.
REQ-009 shift_sel  output  6  left shift applied to the partial product.
REQ-010 upd_prod  output  1  product register accumulate enable.
REQ-011 clr_prod  output  1  product register clear.
REQ-012 busy  output  1  high in every step state.
REQ-013 done  output  1  one-cycle pulse; product is valid in this cycle.
REQ-014 step_count  output  4  number of accumulate steps used by the last completed operation.

Function
REQ-015 States: IDLE, A0B0, A1B0, A2B0, A3B0, A0B1, A1B1, A2B1, A3B1; AiBj selects a byte i and b word j.
REQ-016 In state AiBj: a_sel=i, b_sel=j, shift_sel=8*i+16*j, upd_prod=1, busy=1, clr_prod=0 (all Moore outputs).
REQ-017 In IDLE: a_sel=0, b_sel=0, shift_sel=0, upd_prod=0, busy=0; clr_prod=start (Mealy).
REQ-018 IDLE with start=1 -> A0B0; IDLE with start=0 -> IDLE.
REQ-019 Full order: A0B0, A1B0, A2B0, A3B0, A0B1, A1B1, A2B1, A3B1 -> IDLE.
REQ-020 Skip (see Configuration): from A2B0, a_msb_is_0 skips A3B0; from A2B0/A3B0, b_msw_is_0 goes to IDLE; from A2B1, a_msb_is_0 goes to IDLE.
REQ-021 done is registered: high for exactly one cycle, the cycle after the last step state (first IDLE cycle).
REQ-022 Latency: start accepted at cycle 0; N steps occupy cycles 1..N; done at cycle N+1; N in {3,4,6,8}.
REQ-023 step_count is updated when done rises and holds until the next done.
REQ-024 start while busy is ignored: no restart, no clr_prod.
REQ-025 start during the done cycle is accepted, so back-to-back operations have zero idle gap.
REQ-026 The requester holds a and b stable from start until done; flags are sampled combinationally in each step state.

Reset
REQ-027 Reset forces IDLE and sets done=0 and step_count=0; all outputs take their IDLE values with start=0.
REQ-028 Reset mid-operation aborts immediately; no done pulse is issued for the aborted operation.

Configuration
REQ-029 Macro MULT32X32_FAST_SKIP_EN: when defined, REQ-020 skipping applies.
REQ-030 When MULT32X32_FAST_SKIP_EN is undefined, the flag inputs are ignored and every operation takes 8 steps.

Structure
REQ-031 The shared package mult32x32_pkg holds:
- the state enum typedef;
- constants STEPS_MAX=8 and BYTE_SHIFT=8;
- a shift function of (a_sel, b_sel).
REQ-032 There is no sub-module; the top level mult32x32_fast instantiates this block together with mult32x32_fast_arith.

Verification
REQ-033 a=0xFFFFFFFF, b=0xFFFFFFFF, start:
- upd_prod high in cycles 1-8 with shift_sel 0,8,16,24,16,24,32,40;
- done at cycle 9, product=0xFFFFFFFE00000001, step_count=8.
REQ-034 a=0x00FFFFFF, b=0x0000FFFF with SKIP_EN: 3 steps, done at cycle 4, product=0x000000FFFEFF0001, step_count=3.
REQ-035 a=0x12345678, b=0x00001000 with SKIP_EN: 4 steps, done at cycle 5, product=0x0000012345678000.
REQ-036 Same stimulus as REQ-034 without SKIP_EN: 8 steps, done at cycle 9, identical product.
REQ-037 Reset asserted in A2B0: next cycle IDLE, busy=0, no done pulse, product=0.
REQ-038 Handshake corners:
- start held high during busy: no effect on the sequence;
- start during the done cycle: clr_prod=1 that cycle and A0B0 on the next cycle.
